// File: rtl/circ_alloc.sv
// circ_alloc: circular slot allocator.
// Keeps a W-bit occupancy vector and a rotating search pointer. Each cycle it offers the
// first free slot found circularly from the pointer (pointer slot visited last) on a
// valid/ready allocate port, and it reclaims slots through an independent free port.
// Allocations are spread around the pool instead of always reusing the lowest index.
//
// Parameters:
//   W    - number of slots (> 0)
//   DESC - search direction: 1 = ptr-1, ptr-2, ... wrapping; 0 = ptr+1, ptr+2, ... wrapping
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   alloc_vld_i  - allocation request
//   alloc_rdy_o  - a free slot exists
//   alloc_id_o   - candidate slot (0 when full)
//   free_vld_i   - release request
//   free_id_i    - slot to release
//   occ_o        - occupancy vector (1 = allocated)
//   cnt_o        - number of allocated slots
//   full_o       - all slots allocated
//   empty_o      - no slot allocated
//   err_o        - sticky error: double-free or out-of-range free
module circ_alloc #(
  parameter int unsigned W    = 32,
  parameter bit          DESC = 1'b1,
  localparam int unsigned IW  = (W > 1) ? $clog2(W) : 1,
  localparam int unsigned CW  = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_vld_i,
  output logic          alloc_rdy_o,
  output logic [IW-1:0] alloc_id_o,
  input  logic          free_vld_i,
  input  logic [IW-1:0] free_id_i,
  output logic [W-1:0]  occ_o,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  if (W == 0) begin : g_bad_w
    $error("circ_alloc: W must be > 0");
  end

  logic [W-1:0]  r_occ;
  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic          w_found;
  logic [IW-1:0] w_cand;
  logic          w_fire;
  logic          w_free_in_rng;
  logic          w_free_hit;
  logic          w_free_ok;
  logic          w_free_err;
  logic [W-1:0]  w_occ_d;

  // Candidate search over registered state only. Step k = 1..W away from the pointer,
  // so the pointer slot itself (k = W) is visited last.
  always_comb begin
    int unsigned   s;
    logic [IW-1:0] idx;
    s       = 0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= W; k++) begin
      if (DESC) begin
        s = 32'(r_ptr) + W - k;
      end else begin
        s = 32'(r_ptr) + k;
      end
      if (s >= W) begin
        s = s - W;
      end
      idx = IW'(s);
      if (!w_found && !r_occ[idx]) begin
        w_found = 1'b1;
        w_cand  = idx;
      end
    end
  end

  assign w_fire = alloc_vld_i & w_found;

  // Validity is judged against pre-free occupancy, so freeing the slot granted in the
  // same cycle counts as a double-free.
  assign w_free_in_rng = ({1'b0, free_id_i} < (IW + 1)'(W));
  assign w_free_hit    = w_free_in_rng ? r_occ[free_id_i] : 1'b0;
  assign w_free_ok     = free_vld_i & w_free_hit;
  assign w_free_err    = free_vld_i & ~w_free_hit;

  // A valid free always targets an allocated slot, the grant a free one: never the same bit.
  always_comb begin
    w_occ_d = r_occ;
    if (w_free_ok) begin
      w_occ_d[free_id_i] = 1'b0;
    end
    if (w_fire) begin
      w_occ_d[w_cand] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_occ <= w_occ_d;
      if (w_fire) begin
        r_ptr <= w_cand;
      end
      r_cnt <= r_cnt + CW'(w_fire) - CW'(w_free_ok);
      if (w_free_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign full_o      = &r_occ;
  assign empty_o     = ~|r_occ;
  assign alloc_rdy_o = w_found;
  assign alloc_id_o  = w_cand;
  assign occ_o       = r_occ;
  assign cnt_o       = r_cnt;
  assign err_o       = r_err;

endmodule

// File: doc/circ_alloc.md
# circ_alloc

Sequential circular slot allocator built on the codebase's circular first-zero search. It holds a W-bit occupancy vector and a rotating search pointer. Each cycle it offers the next free slot, found circularly from the pointer, over a valid/ready allocate port, and it reclaims slots through an independent free port. It sits in front of tag/ID pools (request trackers, buffer-entry managers) and spreads allocations fairly instead of always reusing the lowest index.

## Interface
- W, 32: number of slots; must be > 0 (static assertion).
- DESC, 1'b1: search direction. 1 = descending (ptr-1, ptr-2, …, 0, W-1, …, ptr). 0 = ascending (ptr+1, …, W-1, 0, …, ptr).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- alloc_vld_i  in  1  allocation request.
- alloc_rdy_o  out  1  a free slot exists (= ~full_o).
- alloc_id_o  out  $clog2(W) (min 1)  candidate slot index; valid when alloc_rdy_o = 1.
- free_vld_i  in  1  release request.
- free_id_i  in  $clog2(W) (min 1)  slot to release.
- occ_o  out  W  occupancy vector (1 = allocated).
- cnt_o  out  $clog2(W+1)  number of allocated slots.
- full_o  out  1  occ_o all ones.
- empty_o  out  1  occ_o all zeros.
- err_o  out  1  sticky protocol error; cleared only by rst.

## Operation
- State: occ[W-1:0], ptr[$clog2(W)-1:0], cnt, err.
- Candidate:
  - It is the first 0 in occ, visited in the DESC order from ptr; ptr itself is visited last.
  - It is computed combinationally from registered state only, with no path from any input.
  - alloc_id_o is its binary encoding.
  - When full, alloc_id_o is don't-care but must be stable (drive 0).
- Alloc fire = alloc_vld_i & alloc_rdy_o. On fire:
  - occ[alloc_id_o] <= 1.
  - ptr <= alloc_id_o, so the next search resumes beyond the granted slot.
- alloc_vld_i while full: no state change and no error; the requester waits.
- Free, on free_vld_i:
  - If free_id_i < W and occ[free_id_i] = 1: occ[free_id_i] <= 0.
  - Otherwise (double-free, or out-of-range index when W is not a power of 2): ignore the request and set err <= 1.
  - ptr is unaffected by a free.
- Simultaneous alloc fire and free in one cycle:
  - Both apply.
  - The candidate is computed from pre-free occ, so a slot freed this cycle is not grantable until the next cycle.
  - The granted slot is free in pre-free occ, so a same-cycle free of that index is a double-free: set err, and the slot ends allocated.
- cnt update:
  - cnt <= cnt + fire - valid_free.
  - valid_free excludes erroneous frees.
  - cnt never wraps; it stays consistent with popcount(occ).
- W = 1:
  - ptr is constant 0.
  - The candidate is slot 0 iff occ = 0.
  - Index ports are 1 bit wide; free_id_i = 1 is out of range.

## Timing
- Reset (rst high at a clock edge):
  - occ = 0, ptr = 0, cnt = 0, err = 0.
  - Therefore empty_o = 1, full_o = 0, alloc_rdy_o = 1.
  - alloc_id_o = W-1 for DESC=1; 1 for DESC=0 (0 when W = 1).
- rst dominates any same-cycle alloc fire or free; in-flight requests are dropped.
- alloc_rdy_o, alloc_id_o, full_o, empty_o, occ_o, cnt_o and err_o are all functions of registers only.
- Allocation latency: grant is in the same cycle as fire. occ_o, cnt_o and the new candidate reflect it on the next cycle.
- Free latency: effect visible on the cycle after free_vld_i.
- Throughput: one alloc plus one free per cycle, sustained.
- Full boundary: the last alloc makes full_o = 1 next cycle. A free in that same cycle keeps full_o = 0.
- err_o rises the cycle after the offending free and holds until rst.

## Test plan
- Reset, W=16, DESC=1: hold alloc_vld_i for 16 cycles → ids 15,14,…,0 in order; then full_o = 1, alloc_rdy_o = 0, cnt_o = 16; a 17th request produces no grant and err_o stays 0.
- W=16, DESC=1, occ = 16'h2A37 (preloaded by allocating then freeing), ptr = 8 → alloc_id_o = 7. After fire, ptr = 7 and the next id is 6 (the next free slot below 7, rotating down through 0 into W-1).
- Full W=8 pool, same-cycle alloc request and free_id_i = 3 → no grant that cycle; next cycle alloc_id_o = 3 and cnt_o = 7.
- Free of a free slot (id 5) and free_id_i = 20 with W=20 → both ignored; occ_o unchanged; err_o = 1 from the next cycle until rst.
- DESC=0, W=5, from reset: allocs grant 1,2,3,4,0 in order; free 2, then alloc → grants 2. Assert rst mid-stream → all outputs return to reset values on the next cycle.
